// File: rtl/DEF.sv
// Shared types for the multi-cycle branch-condition unit.
//   dw            : operand type at the default RV64 width
//   br_funct3_e   : RV64I branch encodings (funct3)
//   brcmp_state_e : controller states
//   taken_of()    : maps funct3 plus the eq/lt results to the branch decision
package DEF;
    localparam int XLEN_DEF = 64;

    typedef logic [XLEN_DEF-1:0] dw;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } brcmp_state_e;

    function automatic logic is_illegal(input logic [2:0] f3);
        return f3[2:1] == 2'b01;
    endfunction

    // 010 and 011 fall into the default arm, so they are never taken.
    function automatic logic taken_of(input logic [2:0] f3, input logic eq, input logic lt);
        logic t;
        case (f3)
            BEQ:        t = eq;
            BNE:        t = !eq;
            BLT, BLTU:  t = lt;
            BGE, BGEU:  t = !lt;
            default:    t = 1'b0;
        endcase
        return t;
    endfunction
endpackage

// File: rtl/branch_cond_unit_if.sv
// Request/response bundle of the branch-condition unit.
//   master : the pipeline side that issues requests and consumes results
//   slave  : the branch_cond_unit itself
// Request : in_valid, in_ready, operand_1, operand_2, funct3, flush
// Response: out_valid, out_ready, taken, br_eq, br_lt, illegal
interface branch_cond_unit_if #(parameter int XLEN = 64);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] operand_1;
    logic [XLEN-1:0] operand_2;
    logic [2:0]      funct3;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic            taken;
    logic            br_eq;
    logic            br_lt;
    logic            illegal;

    modport master (
        output in_valid, operand_1, operand_2, funct3, flush, out_ready,
        input  in_ready, out_valid, taken, br_eq, br_lt, illegal
    );

    modport slave (
        input  in_valid, operand_1, operand_2, funct3, flush, out_ready,
        output in_ready, out_valid, taken, br_eq, br_lt, illegal
    );
endinterface

// File: rtl/brcmp_chunk.sv
// Combinational slice comparator: one CHUNK-bit slice per cycle.
//   a, b      : slice operands
//   is_signed : compare as two's complement (only for the top slice of a signed branch)
//   eq, lt    : a == b, a < b
module brcmp_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             is_signed,
    output logic             eq,
    output logic             lt
);
    assign eq = (a == b);
    assign lt = is_signed ? ($signed(a) < $signed(b)) : (a < b);
endmodule

// File: rtl/branch_cond_unit.sv
// Multi-cycle RV64I branch-condition unit. Scans the operands one CHUNK-bit
// slice per cycle from the MSB slice down; the first unequal slice decides lt.
// Ports: clk, rst_n (async, active low), bus (branch_cond_unit_if.slave).
// Option: define BRCMP_EARLY_EXIT_EN to finish as soon as the first unequal
// slice is found; otherwise latency is always NCHUNK compare cycles.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// CMP   | comparing slice idx_q, counting down to 0
// DONE  | result registered, out_valid=1 until out_ready or flush
module branch_cond_unit
    import DEF::*;
#(
    parameter int XLEN  = 64,
    parameter int CHUNK = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_cond_unit_if.slave  bus
);
    localparam int NCHUNK = XLEN / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

    brcmp_state_e    state_q, state_nx;
    logic [XLEN-1:0] op1_q, op2_q;
    logic [2:0]      f3_q;
    logic [IDXW-1:0] idx_q;
    logic            diff_q, lt_q;
    logic            out_valid_q, taken_q, br_eq_q, br_lt_q, illegal_q;

    logic [CHUNK-1:0] slice_a, slice_b;
    logic             is_signed, c_eq, c_lt, last, cmp_end;
    logic             diff_nx, lt_nx;

    assign slice_a   = op1_q[int'(idx_q) * CHUNK +: CHUNK];
    assign slice_b   = op2_q[int'(idx_q) * CHUNK +: CHUNK];
    assign is_signed = (idx_q == IDX_TOP) && !f3_q[1];
    assign last      = (idx_q == '0);

    brcmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a         (slice_a),
        .b         (slice_b),
        .is_signed (is_signed),
        .eq        (c_eq),
        .lt        (c_lt)
    );

    // lt is owned by the first differing slice; lower slices cannot override it.
    assign diff_nx = diff_q | !c_eq;
    assign lt_nx   = diff_q ? lt_q : c_lt;

`ifdef BRCMP_EARLY_EXIT_EN
    assign cmp_end = last || !c_eq;
`else
    assign cmp_end = last;
`endif

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid && !bus.flush) state_nx = CMP;
            CMP:     if (bus.flush) state_nx = IDLE;
                     else if (cmp_end) state_nx = DONE;
            DONE:    if (bus.flush || bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op1_q       <= '0;
            op2_q       <= '0;
            f3_q        <= '0;
            idx_q       <= '0;
            diff_q      <= 1'b0;
            lt_q        <= 1'b0;
            out_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            br_eq_q     <= 1'b0;
            br_lt_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_nx;
            out_valid_q <= (state_nx == DONE);
            if (state_q == IDLE && state_nx == CMP) begin
                op1_q  <= bus.operand_1;
                op2_q  <= bus.operand_2;
                f3_q   <= bus.funct3;
                idx_q  <= IDX_TOP;
                diff_q <= 1'b0;
                lt_q   <= 1'b0;
            end
            if (state_q == CMP) begin
                idx_q  <= idx_q - 1'b1;
                diff_q <= diff_nx;
                lt_q   <= lt_nx;
                if (state_nx == DONE) begin
                    br_eq_q   <= !diff_nx;
                    br_lt_q   <= lt_nx & diff_nx;
                    taken_q   <= taken_of(f3_q, !diff_nx, lt_nx & diff_nx);
                    illegal_q <= is_illegal(f3_q);
                end
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.taken     = taken_q;
    assign bus.br_eq     = br_eq_q;
    assign bus.br_lt     = br_lt_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Multi-cycle branch-condition unit for the RV64I execute stage, generalising the single-cycle equal/less-than comparator. It evaluates the full RV64I branch condition set from `funct3` over operands of parametrised width. The compare proceeds one `CHUNK`-bit slice per cycle, from the MSB slice downward, so each cycle carries a narrow comparator. Valid/ready handshakes on input and output let the pipeline stall around it.

## Interface

Parameters:
- `XLEN`, 64: operand width. Must be a multiple of `CHUNK`.
- `CHUNK`, 16: bits compared per cycle. Must be a power of two, ≥ 8. Derived: `NCHUNK = XLEN/CHUNK`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: unit can accept a request.
- `operand_1` in XLEN: rs1 value.
- `operand_2` in XLEN: rs2 value.
- `funct3` in 3: branch type.
- `flush` in 1: synchronous kill of any in-flight or held result.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `taken` out 1: branch condition true.
- `br_eq` out 1: operands equal.
- `br_lt` out 1: operand_1 < operand_2. Signed unless `funct3[1]` is 1.
- `illegal` out 1: `funct3` is 010 or 011.

## Operation

- FSM states: IDLE, CMP, DONE.
- `in_ready` is 1 iff state is IDLE.
- IDLE→CMP on `in_valid && in_ready && !flush`.
  - Latches the operands and `funct3`.
  - Sets the chunk index to `NCHUNK-1`.
  - Clears the `diff_found` flag.
- CMP: each cycle compares slice `[idx*CHUNK +: CHUNK]`.
  - Slice `NCHUNK-1` is compared signed when `funct3[1]==0`. All other slices are compared unsigned.
  - On the first unequal slice: latch `lt` and set `diff_found`. Later slices never change `lt`.
  - After slice 0 (or the early exit, see Configuration), go to DONE with `br_eq = !diff_found` and `br_lt = lt & diff_found`.
- `taken` is decoded from `funct3`:
  - BEQ 000: `eq`
  - BNE 001: `!eq`
  - BLT 100: `lt`
  - BGE 101: `!lt`
  - BLTU 110: `lt`
  - BGEU 111: `!lt`
- Illegal `funct3` (010, 011): the compare runs normally; `taken=0` and `illegal=1`.
- DONE:
  - `out_valid=1`. `taken`, `br_eq`, `br_lt` and `illegal` are held stable.
  - `out_valid && out_ready` → IDLE.
- `flush`, from any state → IDLE at the next edge.
  - `out_valid` drops. No result is produced.
  - A flush takes priority over an accept or output handshake in the same cycle.

## Timing

- Reset values:
  - state IDLE, so `in_ready=1`.
  - `out_valid`, `taken`, `br_eq`, `br_lt`, `illegal` all 0.
- All outputs are registered. `in_ready` is decoded from the state register.
- Let k be the number of slices examined. The accept edge is E0.
  - `out_valid` rises after edge Ek.
  - k ranges from 1 to `NCHUNK`.
- No bypass from DONE to accept. The next accept happens at the earliest one cycle after the output handshake, so the minimum period is k+2 cycles.
- Holding `out_ready` low keeps DONE indefinitely with outputs unchanged.
- `rst_n` low mid-operation aborts immediately to the reset values.

## Configuration

- `BRCMP_EARLY_EXIT_EN` defined:
  - CMP→DONE in the same cycle the first unequal slice is found, so k = slice position from the top + 1.
  - Equal operands give k = `NCHUNK`.
- Not defined:
  - Always k = `NCHUNK` (fixed latency).
  - After the first difference, slices are still scanned but ignored.

## Structure

- Package `DEF` holds:
  - `dw` (operand type).
  - `br_funct3_e` enum (BEQ, BNE, BLT, BGE, BLTU, BGEU).
  - `brcmp_state_e` enum (IDLE, CMP, DONE).
- Sub-module `brcmp_chunk` is the combinational slice comparator.
  - Parameter: `CHUNK`.
  - Inputs: `a`, `b`, `is_signed`.
  - Outputs: `eq`, `lt`.

## Test plan

All cases use XLEN=64, CHUNK=16.

1. BEQ, both operands 0x123456789ABCDEF0 → `taken=1`, `br_eq=1`, `br_lt=0`; `out_valid` 4 cycles after accept in both configs.
2. BLT, `op1=0xFFFFFFFFFFFFFFFF` (−1), `op2=1` → `br_lt=1`, `taken=1`; latency 1 with `BRCMP_EARLY_EXIT_EN`, 4 without.
3. BLTU, same operands as case 2 → `br_lt=0`, `taken=0`, `br_eq=0`; latency 1 with the macro.
4. BGE, `op1=5`, `op2=3` (differ only in slice 0) → `br_lt=0`, `taken=1`, `br_eq=0`; latency 4.
5. Hold `out_ready=0` for 3 cycles after `out_valid` → outputs stable and `in_ready=0` throughout. A new request with `flush=1` during CMP → IDLE next cycle, `out_valid` never asserted.
6. `funct3=010`, equal operands → `illegal=1`, `taken=0`, `br_eq=1`.
